// File: rtl/mpmc11_pkg.sv
// rtl/mpmc11_pkg.sv - shared types and widths for the mpmc11 channel arbiter
package mpmc11_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RECOVER
    } mpmc11_arb_state_t;

    localparam int MPMC11_TO_W     = 16;
    localparam int MPMC11_STARVE_W = 8;

endpackage

// File: rtl/mpmc11_rr_pick.sv
// rtl/mpmc11_rr_pick.sv - round-robin search of a request mask starting after last
module mpmc11_rr_pick #(
    parameter  int NCH = 8,
    localparam int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] mask,
    input  logic [CW-1:0]  last,
    output logic           found,
    output logic [CW-1:0]  idx
);

    int c;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        // last itself is visited at i == NCH, so a lone requester can win again
        for (int i = 1; i <= NCH; i++) begin
            c = int'(last) + i;
            if (c >= NCH) begin
                c = c - NCH;
            end
            if (!found && mask[c]) begin
                found = 1'b1;
                idx   = CW'(c);
            end
        end
    end

endmodule

// File: rtl/mpmc11_ch_arbiter.sv
// rtl/mpmc11_ch_arbiter.sv - round-robin channel arbiter with priority, starvation promotion and grant watchdog
module mpmc11_ch_arbiter
    import mpmc11_pkg::*;
#(
    parameter  int NCH         = 8,
    parameter  int TO_LIMIT    = 512,
    parameter  int STARVE_LIM  = 64,
    parameter  int RECOVER_CYC = 4,
    localparam int CW          = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         prio,
    input  logic                   mem_ready,
    input  logic                   done,
    output logic [NCH-1:0]         gnt,
    output logic                   gnt_valid,
    output logic [CW-1:0]          gnt_ch,
    output logic                   timeout,
    output logic [MPMC11_TO_W-1:0] to_cnt
);

    mpmc11_arb_state_t          state_q, state_d;
    logic [NCH-1:0]             gnt_q, gnt_d;
    logic [CW-1:0]              gnt_ch_q, gnt_ch_d;
    logic [CW-1:0]              last_q, last_d;
    logic [MPMC11_TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                       timeout_q, timeout_d;
    logic [3:0]                 rec_q, rec_d;
    logic [MPMC11_STARVE_W-1:0] starve_q [NCH];
    logic [MPMC11_STARVE_W-1:0] starve_d [NCH];

    logic [NCH-1:0] starved;
    logic           f_starve, f_prio, f_any;
    logic [CW-1:0]  i_starve, i_prio, i_any, win;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            starved[i] = req[i] && (starve_q[i] == MPMC11_STARVE_W'(STARVE_LIM));
        end
    end

    mpmc11_rr_pick #(.NCH(NCH)) u_pick_starve (.mask(starved),    .last(last_q), .found(f_starve), .idx(i_starve));
    mpmc11_rr_pick #(.NCH(NCH)) u_pick_prio   (.mask(req & prio), .last(last_q), .found(f_prio),   .idx(i_prio));
    mpmc11_rr_pick #(.NCH(NCH)) u_pick_any    (.mask(req),        .last(last_q), .found(f_any),    .idx(i_any));

    assign win = f_starve ? i_starve : (f_prio ? i_prio : i_any);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_ch_d  = gnt_ch_q;
        last_d    = last_q;
        to_cnt_d  = '0;
        timeout_d = 1'b0;
        rec_d     = '0;
        case (state_q)
            ARB_IDLE: begin
                if (|req && mem_ready) begin
                    state_d  = ARB_BUSY;
                    gnt_d    = NCH'(1) << win;
                    gnt_ch_d = win;
                end
            end
            ARB_BUSY: begin
                // done takes precedence over the watchdog on the same cycle
                if (done || (to_cnt_q == MPMC11_TO_W'(TO_LIMIT - 1))) begin
                    state_d   = done ? ARB_IDLE : ARB_RECOVER;
                    timeout_d = !done;
                    gnt_d     = '0;
                    gnt_ch_d  = '0;
                    last_d    = gnt_ch_q;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ARB_RECOVER: begin
                if (rec_q == 4'(RECOVER_CYC - 1)) begin
                    state_d = ARB_IDLE;
                end else begin
                    rec_d = rec_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (!req[i] || gnt_q[i]) begin
                starve_d[i] = '0;
            end else if (starve_q[i] != MPMC11_STARVE_W'(STARVE_LIM)) begin
                starve_d[i] = starve_q[i] + 1'b1;
            end else begin
                starve_d[i] = starve_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            gnt_ch_q  <= '0;
            last_q    <= CW'(NCH - 1);
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            rec_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                starve_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_ch_q  <= gnt_ch_d;
            last_q    <= last_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            rec_q     <= rec_d;
            for (int i = 0; i < NCH; i++) begin
                starve_q[i] <= starve_d[i];
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_ch    = gnt_ch_q;
    assign timeout   = timeout_q;
    assign to_cnt    = to_cnt_q;

endmodule

// File: tb/tb_mpmc11_ch_arbiter.sv
// tb/tb_mpmc11_ch_arbiter.sv - directed self-checking bench for mpmc11_ch_arbiter
module tb_mpmc11_ch_arbiter;

    localparam int NCH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  req;
    logic [7:0]  prio;
    logic        mem_ready;
    logic        done;
    logic [7:0]  gnt;
    logic        gnt_valid;
    logic [2:0]  gnt_ch;
    logic        timeout;
    logic [15:0] to_cnt;

    int n_checks = 0;
    int n_errors = 0;

    mpmc11_ch_arbiter #(
        .NCH(NCH), .TO_LIMIT(512), .STARVE_LIM(64), .RECOVER_CYC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .prio(prio),
        .mem_ready(mem_ready), .done(done), .gnt(gnt), .gnt_valid(gnt_valid),
        .gnt_ch(gnt_ch), .timeout(timeout), .to_cnt(to_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},     32'(gnt),       32'h0);
        check({tag, "_valid"},   32'(gnt_valid), 32'h0);
        check({tag, "_gnt_ch"},  32'(gnt_ch),    32'h0);
        check({tag, "_timeout"}, 32'(timeout),   32'h0);
        check({tag, "_to_cnt"},  32'(to_cnt),    32'h0);
    endtask

    // Expects IDLE with req applied: grant on the next edge, done two cycles later, then an idle cycle.
    task automatic grant_cycle(input int exp_ch, input string tag);
        tick();
        check({tag, "_valid"}, 32'(gnt_valid), 32'h1);
        check({tag, "_ch"},    32'(gnt_ch),    32'(exp_ch));
        check({tag, "_gnt"},   32'(gnt),       32'h1 << exp_ch);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check({tag, "_gap"}, 32'(gnt_valid), 32'h0);
    endtask

    int elapsed;
    int at_ch1;
    int n0;
    int n_other;
    bit seen1;

    initial begin
        rst_n = 1'b0; req = '0; prio = '0; mem_ready = 1'b0; done = 1'b0;
        tick(); tick();
        check_idle_outputs("rst_hold");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("rst_rel");

        // first grant, then asynchronous reset while busy
        req = 8'h01; mem_ready = 1'b1;
        tick();
        check("first_valid", 32'(gnt_valid), 32'h1);
        check("first_gnt",   32'(gnt),       32'h01);
        check("first_ch",    32'(gnt_ch),    32'h0);
        tick();
        check("busy_to_cnt", 32'(to_cnt), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        req = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // round robin over all channels, wrapping back to 0
        req = 8'hFF; prio = 8'h00;
        for (int k = 0; k < 9; k++) begin
            grant_cycle(k % 8, $sformatf("rr%0d", k));
        end

        // priority tier beats round robin order, then wrap after 3
        req = 8'h0F; prio = 8'h08;
        grant_cycle(3, "prio");
        req = 8'h07; prio = 8'h00;
        grant_cycle(0, "wrap");
        req = '0;
        tick(); tick();

        // watchdog timeout on ch2
        req = 8'h04;
        tick();
        check("to_ch",     32'(gnt_ch), 32'h2);
        check("to_cnt0",   32'(to_cnt), 32'h0);
        for (int k = 0; k < 511; k++) tick();
        check("to_cnt511", 32'(to_cnt),    32'd511);
        check("to_pre",    32'(timeout),   32'h0);
        check("to_held",   32'(gnt_valid), 32'h1);
        tick();
        check("to_pulse",  32'(timeout),   32'h1);
        check("to_gnt0",   32'(gnt),       32'h0);
        check("to_clr",    32'(to_cnt),    32'h0);
        req = 8'h0C;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rec%0d_gnt", k), 32'(gnt_valid), 32'h0);
            check($sformatf("rec%0d_to", k),  32'(timeout),   32'h0);
        end
        tick();
        check("post_to_valid", 32'(gnt_valid), 32'h1);
        check("post_to_ch",    32'(gnt_ch),    32'h3);

        // done coincident with the last watchdog cycle
        for (int k = 0; k < 511; k++) tick();
        check("co_cnt", 32'(to_cnt), 32'd511);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("co_timeout", 32'(timeout),   32'h0);
        check("co_gnt",     32'(gnt_valid), 32'h0);
        req = '0;
        tick();
        check("co_timeout2", 32'(timeout), 32'h0);
        tick();

        // starvation promotion: ch1 wins at the first arbitration after its counter reaches 64
        req = 8'h03; prio = 8'h01;
        elapsed = 0; at_ch1 = 0; n0 = 0; n_other = 0; seen1 = 1'b0;
        for (int k = 0; k < 120 && !seen1; k++) begin
            tick();
            elapsed++;
            if (gnt_valid) begin
                if (gnt_ch == 3'd1) begin
                    seen1  = 1'b1;
                    at_ch1 = elapsed;
                end else if (gnt_ch == 3'd0) begin
                    n0++;
                end else begin
                    n_other++;
                end
                done = 1'b1;
                tick();
                elapsed++;
                done = 1'b0;
            end
        end
        check("starve_seen",  32'(seen1),   32'h1);
        check("starve_cycle", 32'(at_ch1),  32'd65);
        check("starve_n0",    32'(n0),      32'd32);
        check("starve_other", 32'(n_other), 32'd0);
        tick();
        check("starve_resume_valid", 32'(gnt_valid), 32'h1);
        check("starve_resume_ch",    32'(gnt_ch),    32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
